if_pc_ras: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage: holds the fetch address and advances it sequentially, on predicted-taken branches, or on a redirect from execute. It adds a circular return-address stack (RAS) so call/return pairs predict correctly, and it forces targets onto instruction alignment. It sits at the head of the IF stage and drives the instruction-memory address.

---
 rtl/if_pc_ras.sv | 136 +++++++++++++
 tb/tb_if_pc_ras.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_pc_ras.sv
// Fetch program counter with sequential/branch/redirect next-PC selection,
// target alignment, and an optional circular return-address stack (IF_PC_RAS_EN).
module if_pc_ras #(
    parameter int ADDR_W      = 16,
    parameter int INSTR_BYTES = 2,
    parameter int RESET_VEC   = 0,
    parameter int RAS_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pc_en,
    input  logic                           redirect,
    input  logic [ADDR_W-1:0]              redirect_addr,
    input  logic                           branch_taken,
    input  logic [ADDR_W-1:0]              branch_addr,
    input  logic                           is_call,
    input  logic                           is_ret,
    output logic [ADDR_W-1:0]              pc_addr,
    output logic                           addr_misaligned,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    logic              load;
    logic              misaligned_next;

    assign seq_pc = pc_addr + STEP;

`ifdef IF_PC_RAS_EN
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;   // next free slot; oldest entry when full
    logic [PTR_W-1:0]  top_idx;
    logic              ras_empty;
    logic              ras_full;
    logic              push;
    logic              pop;
    logic              underflow_next;

    assign top_idx   = ras_ptr - PTR_W'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
`endif

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        load    = 1'b0;
        target  = branch_addr;
        pc_next = pc_addr;
`ifdef IF_PC_RAS_EN
        push           = 1'b0;
        pop            = 1'b0;
        underflow_next = 1'b0;
`endif
        if (redirect) begin
            load   = 1'b1;
            target = redirect_addr;
        end else if (pc_en) begin
            pc_next = seq_pc;
`ifdef IF_PC_RAS_EN
            if (is_ret && !ras_empty) begin
                // Pop (and re-push when paired with a call) from the stack top.
                pop    = 1'b1;
                push   = is_call;
                load   = 1'b1;
                target = ras_mem[top_idx];
            end else begin
                underflow_next = is_ret;
                push           = is_call;
                load           = is_call || branch_taken;
            end
`else
            load = branch_taken;
`endif
        end
        if (load) pc_next = target & ~LOW_MASK;
    end

    assign misaligned_next = load && ((target & LOW_MASK) != '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_addr         <= ADDR_W'(RESET_VEC);
            addr_misaligned <= 1'b0;
        end else begin
            pc_addr         <= pc_next;
            addr_misaligned <= misaligned_next;
        end
    end

`ifdef IF_PC_RAS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= push && !pop && ras_full;
            ras_underflow <= underflow_next;
            case ({push, pop})
                2'b10: begin
                    ras_ptr <= ras_ptr + PTR_W'(1);
                    if (!ras_full) ras_count <= ras_count + CNT_W'(1);
                end
                2'b01: begin
                    ras_ptr   <= top_idx;
                    ras_count <= ras_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: stack storage has no reset; the count and pointer alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) ras_mem[pop ? top_idx : ras_ptr] <= seq_pc;
    end
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = is_call | is_ret;
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_if_pc_ras.sv
// Scoreboard bench for if_pc_ras: directed scenarios then random traffic, checked
// against a queue-based model of the next-PC and return-stack rules.
module tb_if_pc_ras;

    localparam int ADDR_W      = 16;
    localparam int INSTR_BYTES = 2;
    localparam int RESET_VEC   = 0;
    localparam int RAS_DEPTH   = 4;
`ifdef IF_PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] pc;
        logic        mis;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic [15:0] pc_addr;
    logic        addr_misaligned;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    logic [15:0] m_pc = 16'(RESET_VEC);
    logic [15:0] m_ras[$];

    if_pc_ras #(
        .ADDR_W(ADDR_W), .INSTR_BYTES(INSTR_BYTES),
        .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .redirect(redirect),
        .redirect_addr(redirect_addr), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .is_call(is_call), .is_ret(is_ret),
        .pc_addr(pc_addr), .addr_misaligned(addr_misaligned),
        .ras_count(ras_count), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's expected post-edge outputs.
    task automatic step(input logic r, input logic en, input logic rd,
                        input logic [15:0] ra, input logic bt,
                        input logic [15:0] ba, input logic c, input logic rt);
        exp_t        e;
        logic [15:0] next_seq;
        logic [15:0] tgt;
        logic        ld;
        @(negedge clk);
        rst = r; pc_en = en; redirect = rd; redirect_addr = ra;
        branch_taken = bt; branch_addr = ba; is_call = c; is_ret = rt;
        e.mis = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
        next_seq = m_pc + 16'(INSTR_BYTES);
        ld = 1'b0; tgt = '0;
        if (r) begin
            m_pc = 16'(RESET_VEC);
            m_ras.delete();
        end else if (rd) begin
            ld = 1'b1; tgt = ra;
        end else if (en) begin
            if (RAS_ON && rt && m_ras.size() > 0) begin
                tgt = m_ras.pop_back();
                ld  = 1'b1;
                if (c) m_ras.push_back(next_seq);
            end else begin
                if (RAS_ON && rt) e.unf = 1'b1;
                if (RAS_ON && c) begin
                    m_ras.push_back(next_seq);
                    if (m_ras.size() > RAS_DEPTH) begin
                        m_ras.delete(0);
                        e.ovf = 1'b1;
                    end
                end
                if ((RAS_ON && c) || bt) begin
                    ld = 1'b1; tgt = ba;
                end
            end
            if (!ld) m_pc = next_seq;
        end
        if (ld) begin
            e.mis = (tgt % INSTR_BYTES) != 0;
            m_pc  = tgt - 16'(tgt % INSTR_BYTES);
        end
        e.pc  = m_pc;
        e.cnt = m_ras.size();
        sb.push_back(e);
    endtask

    // Monitor: one registered result per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_addr", int'(pc_addr), int'(e.pc));
                check("addr_misaligned", int'(addr_misaligned), int'(e.mis));
                check("ras_count", int'(ras_count), e.cnt);
                check("ras_overflow", int'(ras_overflow), int'(e.ovf));
                check("ras_underflow", int'(ras_underflow), int'(e.unf));
            end
        end
    end

    initial begin
        // Reset, three advances, two holds.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1, 16'h0800, 1, 1);
        // Call at 0x0010 then return.
        step(0, 0, 1, 16'h0010, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 16'h0100, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        // Five nested calls, five returns.
        step(0, 0, 1, 16'h0000, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 0, 16'(i * 256), 1, 0);
        repeat (5) step(0, 1, 0, 0, 0, 0, 0, 1);
        // Combined call+ret on empty and non-empty stacks.
        step(0, 1, 0, 0, 0, 16'h0A00, 1, 1);
        step(0, 1, 0, 0, 0, 16'h0B00, 1, 1);
        // Misaligned redirect while a return is requested.
        step(0, 0, 1, 16'h1235, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 16'h2001, 0, 0);
        // Wrap-around, then reset on the same cycle as a call.
        step(0, 0, 1, 16'hFFFE, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 16'h0300, 1, 0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 16'($urandom), $urandom_range(0, 2) == 0,
                 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
